// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encodings, word geometry and lane helper for the instruction memory loader
package imem_loader_pkg;

   localparam int IMEM_WORD_BYTES = 4;

   localparam logic [2:0] LDR_IDLE  = 3'd0;
   localparam logic [2:0] LDR_RECV  = 3'd1;
   localparam logic [2:0] LDR_WRITE = 3'd2;
   localparam logic [2:0] LDR_CHECK = 3'd3;
   localparam logic [2:0] LDR_DONE  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = LDR_IDLE,
      ST_RECV  = LDR_RECV,
      ST_WRITE = LDR_WRITE,
      ST_CHECK = LDR_CHECK,
      ST_DONE  = LDR_DONE
   } ldr_state_e;

   // Little-endian placement: lane 0 is the lowest byte address of the word.
   function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
      logic [31:0] r;
      r = word;
      r[8*lane +: 8] = data;
      return r;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream and instruction memory write port of the loader
interface imem_loader_if #(
   parameter int ADDR_BITS = 10
);
   logic                 byte_valid;
   logic [7:0]           byte_data;
   logic                 byte_ready;
   logic                 mem_we;
   logic [ADDR_BITS-3:0] mem_addr;
   logic [31:0]          mem_wdata;

   modport master (output byte_valid, byte_data,
                   input  byte_ready, mem_we, mem_addr, mem_wdata);

   modport slave  (input  byte_valid, byte_data,
                   output byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - packs accepted bytes into a little-endian 32-bit word
module imem_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        push,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear) begin
         cnt_d  = '0;
         word_d = '0;
      end else if (push) begin
         word_d = lane_insert(word_q, cnt_q, data);
         cnt_d  = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign word      = word_q;
   assign word_full = push && (cnt_q == 2'(IMEM_WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter bit BOOT_HOLD = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_BITS-3:0] len_words,
   imem_loader_if.slave         bus,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error
);

   localparam int WA = ADDR_BITS - 2;

   ldr_state_e    state_q, state_d;
   logic [WA-1:0] word_cnt_q, word_cnt_d;
   logic [WA-1:0] last_q, last_d;
   logic          pack_clear, pack_push, word_full;
   logic [31:0]   packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
   logic          error_q, error_d;
`endif

   assign pack_push = bus.byte_valid && (state_q == ST_RECV);

   imem_byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pack_clear),
      .push      (pack_push),
      .data      (bus.byte_data),
      .word      (packed_word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= '0;
         last_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q      <= '0;
         error_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         last_q     <= last_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
         error_q    <= error_d;
`endif
      end
   end

   // The last word index is stored instead of the count, so len_words==0 wraps to full depth.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      last_d     = last_q;
      pack_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
      error_d    = error_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_RECV;
               word_cnt_d = '0;
               last_d     = len_words - 1'b1;
               pack_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d      = '0;
               error_d    = 1'b0;
`endif
            end
         end
         ST_RECV: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (pack_push) sum_d = sum_q + bus.byte_data;
`endif
            if (word_full) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (word_cnt_q == last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = ST_CHECK;
`else
               state_d = ST_DONE;
`endif
            end else begin
               word_cnt_d = word_cnt_q + 1'b1;
               state_d    = ST_RECV;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (bus.byte_valid) begin
               error_d = (bus.byte_data != sum_q);
               state_d = ST_DONE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.byte_ready = 1'b0;
      bus.mem_we     = 1'b0;
      cpu_hold       = BOOT_HOLD;
      done           = 1'b0;
      case (state_q)
         ST_RECV: begin
            bus.byte_ready = 1'b1;
            cpu_hold       = 1'b1;
         end
         ST_WRITE: begin
            bus.mem_we = 1'b1;
            cpu_hold   = 1'b1;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            bus.byte_ready = 1'b1;
            cpu_hold       = 1'b1;
         end
         ST_DONE: begin
            done     = 1'b1;
            cpu_hold = error_q;
         end
`else
         ST_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
`endif
         default: ;
      endcase
   end

   assign bus.mem_addr  = word_cnt_q;
   assign bus.mem_wdata = packed_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign error = error_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   localparam int AB = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len_words = '0;
   logic        cpu_hold, done, error;

   imem_loader_if #(.ADDR_BITS(AB)) bus ();

   imem_loader #(.ADDR_BITS(AB), .BOOT_HOLD(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len_words (len_words),
      .bus       (bus),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          passed = 0;
   int          wr_addr[$];
   logic [31:0] wr_data[$];
   int          hs_cnt = 0;
   int          b2b = 0;
   logic        prev_we = 1'b0;

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         wr_addr.push_back(int'(bus.mem_addr));
         wr_data.push_back(bus.mem_wdata);
         if (prev_we) b2b++;
      end
      prev_we = (bus.mem_we === 1'b1);
      if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) hs_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] len);
      len_words = len;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit hs = 1'b0;
      int n = 0;
      repeat (gap) tick();
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (!hs && n < 40) begin
         @(negedge clk);
         hs = (bus.byte_ready === 1'b1);
         tick();
         n++;
      end
      bus.byte_valid = 1'b0;
      if (!hs) begin
         total++;
         $display("FAIL send_byte_timeout: byte %h not accepted, required acceptance within 40 cycles", b);
      end
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      total++;
      if (done !== 1'b1) $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, limit);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      tick();
      tick();
      total++; if (bus.byte_ready !== 1'b0) $display("FAIL rst_byte_ready: got %b want 0", bus.byte_ready); else passed++;
      total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); else passed++;
      total++; if (bus.mem_addr !== 8'h00) $display("FAIL rst_mem_addr: got %h want 00", bus.mem_addr); else passed++;
      total++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); else passed++;
      total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
      total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else passed++;
      total++; if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); else passed++;
      rst_n = 1'b1;
      tick();
      total++; if (cpu_hold !== 1'b1) $display("FAIL idle_cpu_hold: got %b want 1", cpu_hold); else passed++;
   endtask

   task automatic test_single_word();
      wr_addr.delete();
      wr_data.delete();
      pulse_start(8'd1);
      send_byte(8'hB7, 0);
      send_byte(8'h40, 0);
      send_byte(8'h06, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      total++; if (bus.mem_we !== 1'b1) $display("FAIL single_we: got %b want 1", bus.mem_we); else passed++;
      total++; if (bus.mem_addr !== 8'h00) $display("FAIL single_addr: got %h want 00", bus.mem_addr); else passed++;
      total++; if (bus.mem_wdata !== 32'h000640B7) $display("FAIL single_wdata: got %h want 000640b7", bus.mem_wdata); else passed++;
      total++; if (bus.byte_ready !== 1'b0) $display("FAIL single_ready_in_write: got %b want 0", bus.byte_ready); else passed++;
      tick();
      total++; if (done !== 1'b1) $display("FAIL single_done: got %b want 1", done); else passed++;
      total++; if (cpu_hold !== 1'b0) $display("FAIL single_hold: got %b want 0", cpu_hold); else passed++;
      total++; if (error !== 1'b0) $display("FAIL single_error: got %b want 0", error); else passed++;
      tick();
      total++; if (wr_addr.size() !== 1) $display("FAIL single_write_count: got %0d want 1", wr_addr.size()); else passed++;
   endtask

   task automatic test_backpressure();
      logic [7:0] bp[8] = '{8'h13, 8'h0F, 8'h50, 8'h04, 8'h13, 8'h0F, 8'hF0, 8'hFF};
      int hs0 = hs_cnt;
      int b2b0 = b2b;
      wr_addr.delete();
      wr_data.delete();
      pulse_start(8'd2);
      for (int i = 0; i < 8; i++) begin
         send_byte(bp[i], 1);
         if (i == 2) begin
            total++; if (wr_data.size() !== 0) $display("FAIL bp_early_write: got %0d writes want 0", wr_data.size()); else passed++;
         end
      end
      wait_done(20);
      tick();
      total++; if (wr_data.size() !== 2) $display("FAIL bp_write_count: got %0d want 2", wr_data.size()); else passed++;
      total++; if (wr_addr[0] !== 0 || wr_data[0] !== 32'h04500F13) $display("FAIL bp_word0: got addr %0d data %h want 0 04500f13", wr_addr[0], wr_data[0]); else passed++;
      total++; if (wr_addr[1] !== 1 || wr_data[1] !== 32'hFFF00F13) $display("FAIL bp_word1: got addr %0d data %h want 1 fff00f13", wr_addr[1], wr_data[1]); else passed++;
      total++; if (hs_cnt - hs0 !== 8) $display("FAIL bp_handshakes: got %0d want 8", hs_cnt - hs0); else passed++;
      total++; if (b2b !== b2b0) $display("FAIL bp_back_to_back_we: got %0d want %0d", b2b, b2b0); else passed++;
   endtask

   task automatic test_reset_mid_load();
      wr_addr.delete();
      wr_data.delete();
      pulse_start(8'd4);
      for (int i = 0; i < 14; i++) send_byte(8'(i + 1), 0);
      total++; if (bus.mem_addr !== 8'd3) $display("FAIL mid_addr_before_reset: got %0d want 3", bus.mem_addr); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.byte_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", bus.byte_ready); else passed++;
      total++; if (bus.mem_addr !== 8'h00) $display("FAIL mid_rst_addr: got %h want 00", bus.mem_addr); else passed++;
      total++; if (bus.mem_wdata !== 32'h0) $display("FAIL mid_rst_wdata: got %h want 0", bus.mem_wdata); else passed++;
      total++; if (cpu_hold !== 1'b1 || done !== 1'b0) $display("FAIL mid_rst_hold_done: got %b%b want 10", cpu_hold, done); else passed++;
      total++; if (wr_addr.size() !== 3) $display("FAIL mid_writes_before_reset: got %0d want 3", wr_addr.size()); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      wr_addr.delete();
      wr_data.delete();
      pulse_start(8'd1);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      tick();
      tick();
      total++; if (wr_addr.size() !== 1 || wr_addr[0] !== 0 || wr_data[0] !== 32'hDDCCBBAA) $display("FAIL mid_restart: got n=%0d addr %0d data %h want 1 0 ddccbbaa", wr_addr.size(), wr_addr[0], wr_data[0]); else passed++;
   endtask

   task automatic test_full_depth();
      int errs = 0;
      logic [31:0] exp;
      wr_addr.delete();
      wr_data.delete();
      pulse_start(8'd0);
      for (int i = 0; i < 1024; i++) send_byte(8'((i * 7 + 3) & 255), 0);
      tick();
      total++; if (done !== 1'b1) $display("FAIL full_done_after_last: got %b want 1", done); else passed++;
      repeat (5) tick();
      total++; if (wr_addr.size() !== 256) $display("FAIL full_write_count: got %0d want 256", wr_addr.size()); else passed++;
      for (int w = 0; w < 256 && w < wr_addr.size(); w++) begin
         for (int k = 0; k < 4; k++) exp[8*k +: 8] = 8'(((4*w + k) * 7 + 3) & 255);
         if (wr_addr[w] !== w || wr_data[w] !== exp) errs++;
      end
      total++; if (errs !== 0) $display("FAIL full_order: got %0d bad words want 0", errs); else passed++;
      total++; if (bus.mem_addr !== 8'd255) $display("FAIL full_last_addr: got %0d want 255", bus.mem_addr); else passed++;
   endtask

   task automatic test_ignored_start_and_reload();
      logic [7:0] rest[8] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
      int hs0;
      wr_addr.delete();
      wr_data.delete();
      pulse_start(8'd3);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      pulse_start(8'd1);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      for (int i = 0; i < 8; i++) send_byte(rest[i], 0);
      wait_done(20);
      tick();
      total++; if (wr_addr.size() !== 3) $display("FAIL ign_write_count: got %0d want 3", wr_addr.size()); else passed++;
      total++; if (wr_data[0] !== 32'h44332211) $display("FAIL ign_word0: got %h want 44332211", wr_data[0]); else passed++;
      total++; if (wr_addr[2] !== 2 || wr_data[2] !== 32'hCCBBAA99) $display("FAIL ign_word2: got addr %0d data %h want 2 ccbbaa99", wr_addr[2], wr_data[2]); else passed++;
      hs0 = hs_cnt;
      bus.byte_valid = 1'b1;
      repeat (3) tick();
      bus.byte_valid = 1'b0;
      total++; if (hs_cnt !== hs0) $display("FAIL ign_valid_in_done: got %0d handshakes want 0", hs_cnt - hs0); else passed++;
      wr_addr.delete();
      wr_data.delete();
      pulse_start(8'd1);
      total++; if (done !== 1'b0 || cpu_hold !== 1'b1) $display("FAIL reload_flags: got done %b hold %b want 0 1", done, cpu_hold); else passed++;
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      tick();
      tick();
      total++; if (wr_addr.size() !== 1 || wr_addr[0] !== 0 || wr_data[0] !== 32'h04030201) $display("FAIL reload_write: got n=%0d addr %0d data %h want 1 0 04030201", wr_addr.size(), wr_addr[0], wr_data[0]); else passed++;
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      pulse_start(8'd1);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      send_byte(8'h0A, 0);
      tick();
      total++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL csum_good: got done %b err %b hold %b want 1 0 0", done, error, cpu_hold); else passed++;
      pulse_start(8'd1);
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
      send_byte(8'h0B, 0);
      tick();
      total++; if (done !== 1'b1 || error !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL csum_bad: got done %b err %b hold %b want 1 1 1", done, error, cpu_hold); else passed++;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_reset_mid_load();
      test_full_depth();
      test_ignored_start_and_reload();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
